// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - main control FSM for the multi-cycle RV32I datapath
//
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw and beq.
// Illegal opcodes and memory timeouts park the FSM in a sticky HALT state.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   opcode[6:0]                instr[6:0] from the instruction register
//   zero                       ALU zero flag (beq compare)
//   mem_ready                  memory completes its access this cycle
//   pc_en, ir_write            PC / IR load strobes
//   adr_src                    memory address select (0=PC, 1=ALUOut)
//   mem_read, mem_write        memory request strobes
//   reg_write                  register file write strobe
//   result_src[1:0]            00=ALUOut, 01=mem data, 10=ALU result
//   alu_src_a[1:0]             00=PC, 01=oldPC, 10=rs1
//   alu_src_b[1:0]             00=rs2, 01=imm, 10=const 4
//   alu_op[1:0]                00=add, 01=subtract, 10=decode funct
//   state[3:0]                 current state encoding (debug)
//   illegal, bus_err           sticky trap causes, cleared only by reset
//   instret[31:0]              retired-instruction count
//
// Build option: define RV_INSTRET_EN to implement the instret counter;
// otherwise instret is tied to zero.

module rv_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_HALT     = 4'd9
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic               mem_state;
    logic               timeout;
    logic               retire;

    // Counter tracks consecutive stalled cycles in a memory state. It reaching
    // WAIT_LIMIT with the access still stalled is the bus timeout; a late
    // mem_ready on that same cycle still completes normally.
    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);
        timeout   = (WAIT_LIMIT > 0) && mem_state && !mem_ready &&
                    (wait_q == CNT_W'(WAIT_LIMIT));
        wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + 1'b1 : '0;
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retire     = 1'b0;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // PC+4 and IR load only when the fetch actually completes.
                pc_en      = mem_ready;
                ir_write   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                // Withdraw the write on the timeout cycle so a dead bus never
                // sees a write strobe coincident with the trap.
                mem_write = !timeout;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_en     = zero;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end

        // Reset abandons the instruction: nothing may strobe while it is held.
        if (reset) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef RV_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // Natural 32-bit wrap; HALT never retires so the count freezes there.
    always_comb begin
        instret_d = instret_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret       = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - self-checking bench for rv_multicycle_ctrl

module tb_rv_multicycle_ctrl;

    localparam int WAIT_LIMIT = 15;
    localparam int CNT_W      = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0]  state;
    logic        illegal, bus_err;
    logic [31:0] instret;

    rv_multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: current state plus the queue of states the decoded
    // instruction still has to walk through.
    int          m_cur;
    int          m_path[$];
    int          m_wait;
    bit          m_ill, m_berr;
    logic [31:0] m_instret;

    int          obs_state[$];
    logic        obs_pcen[$], obs_regw[$], obs_mw[$];
    logic [1:0]  obs_aluop[$], obs_rsrc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op}
    function automatic logic [13:0] exp_ctrl(input int st, input logic rdy,
                                             input logic z, input logic tmo);
        logic pe, iw, as, mr, mw, rw;
        logic [1:0] rs, sa, sb, ao;
        pe = 0; iw = 0; as = 0; mr = 0; mw = 0; rw = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
        case (st)
            0: begin mr = 1; pe = rdy; iw = rdy; sb = 2'b10; rs = 2'b10; end
            1: begin sa = 2'b01; sb = 2'b01; end
            2: begin sa = 2'b10; sb = 2'b01; end
            3: begin mr = 1; as = 1; end
            4: begin rs = 2'b01; rw = 1; end
            5: begin mw = !tmo; as = 1; end
            6: begin sa = 2'b10; ao = 2'b10; end
            7: begin rw = 1; end
            8: begin sa = 2'b10; ao = 2'b01; pe = z; end
            default: ;
        endcase
        return {pe, iw, as, mr, mw, rw, rs, sa, sb, ao};
    endfunction

    function automatic bit is_mem(input int st);
        return (st == 0) || (st == 3) || (st == 5);
    endfunction

    task automatic step();
        logic [13:0] exp_c, act_c;
        logic        tmo;
        logic [31:0] exp_ir;
        @(negedge clk);
        tmo   = is_mem(m_cur) && !mem_ready && (WAIT_LIMIT > 0) && (m_wait == WAIT_LIMIT);
        exp_c = reset ? 14'd0 : exp_ctrl(m_cur, mem_ready, zero, tmo);
        act_c = {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op};
`ifdef RV_INSTRET_EN
        exp_ir = m_instret;
`else
        exp_ir = 32'd0;
`endif
        chk("ctrl", 32'(act_c), 32'(exp_c));
        chk("state", 32'(state), 32'(m_cur));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("bus_err", 32'(bus_err), 32'(m_berr));
        chk("instret", instret, exp_ir);
        obs_state.push_back(int'(state));
        obs_pcen.push_back(pc_en);
        obs_regw.push_back(reg_write);
        obs_mw.push_back(mem_write);
        obs_aluop.push_back(alu_op);
        obs_rsrc.push_back(result_src);

        if (reset) begin
            m_cur = 0; m_path.delete(); m_wait = 0;
            m_ill = 0; m_berr = 0; m_instret = 32'd0;
        end else if (m_cur == 9) begin
            m_cur = 9;
        end else if (is_mem(m_cur) && !mem_ready) begin
            if (tmo) begin
                m_cur = 9; m_berr = 1; m_wait = 0; m_path.delete();
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            if (m_cur == 0) begin
                m_cur = 1;
            end else if (m_cur == 1) begin
                case (opcode)
                    OP_LW:   m_path = '{2, 3, 4};
                    OP_SW:   m_path = '{2, 5};
                    OP_R:    m_path = '{6, 7};
                    OP_BEQ:  m_path = '{8};
                    default: m_path.delete();
                endcase
                if (m_path.size() == 0) begin
                    m_cur = 9; m_ill = 1;
                end else begin
                    m_cur = m_path.pop_front();
                end
            end else if (m_path.size() > 0) begin
                m_cur = m_path.pop_front();
            end else begin
                m_cur = 0;
                m_instret = m_instret + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_state.delete(); obs_pcen.delete(); obs_regw.delete();
        obs_mw.delete(); obs_aluop.delete(); obs_rsrc.delete();
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        mem_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic run_seq(input logic [6:0] op, input logic z, input int n, input logic [63:0] rdy);
        opcode = op;
        zero   = z;
        clear_obs();
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy[i];
            step();
        end
    endtask

    int burst;
    int r;
    logic [6:0] ops [4];

    initial begin
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ};
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
        m_cur = 0; m_wait = 0; m_ill = 0; m_berr = 0; m_instret = 32'd0;
        @(posedge clk);
        #1;

        // Reset held with mem_ready high: no strobes.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pc_en", 32'(pc_en), 32'd0);
            chk("rst_ir_write", 32'(ir_write), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
        end
        reset = 1'b0;

        // R-type, no wait states.
        run_seq(OP_R, 1'b0, 5, 64'hFF);
        chk("r_s1", 32'(obs_state[1]), 32'd1);
        chk("r_s2", 32'(obs_state[2]), 32'd6);
        chk("r_s3", 32'(obs_state[3]), 32'd7);
        chk("r_s4", 32'(obs_state[4]), 32'd0);
        chk("r_aluop", 32'(obs_aluop[2]), 32'd2);
        chk("r_regw7", 32'(obs_regw[3]), 32'd1);
        chk("r_regw6", 32'(obs_regw[2]), 32'd0);
`ifdef RV_INSTRET_EN
        chk("r_instret", instret, 32'd1);
`endif

        // lw with two stalls in MEMREAD: 0,1,2,3,3,3,4,0.
        rst_pulse();
        run_seq(OP_LW, 1'b0, 8, 64'h67);
        chk("lw_s3", 32'(obs_state[3]), 32'd3);
        chk("lw_s5", 32'(obs_state[5]), 32'd3);
        chk("lw_s6", 32'(obs_state[6]), 32'd4);
        chk("lw_s7", 32'(obs_state[7]), 32'd0);
        chk("lw_rsrc", 32'(obs_rsrc[6]), 32'd1);
        chk("lw_regw", 32'(obs_regw[6]), 32'd1);
        chk("lw_berr", 32'(bus_err), 32'd0);

        // beq taken and not taken.
        rst_pulse();
        run_seq(OP_BEQ, 1'b1, 4, 64'h7);
        chk("beq1_state", 32'(obs_state[2]), 32'd8);
        chk("beq1_pcen", 32'(obs_pcen[2]), 32'd1);
        chk("beq1_aluop", 32'(obs_aluop[2]), 32'd1);
        chk("beq1_ret", 32'(obs_state[3]), 32'd0);
        rst_pulse();
        run_seq(OP_BEQ, 1'b0, 4, 64'h7);
        chk("beq0_pcen", 32'(obs_pcen[2]), 32'd0);
        chk("beq0_ret", 32'(obs_state[3]), 32'd0);

        // Illegal opcode traps and stays halted.
        rst_pulse();
        run_seq(OP_BAD, 1'b0, 23, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ill_s2", 32'(obs_state[2]), 32'd9);
        chk("ill_s22", 32'(obs_state[22]), 32'd9);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_berr", 32'(bus_err), 32'd0);
        rst_pulse();
        chk("ill_rst_state", 32'(state), 32'd0);
        chk("ill_rst_flag", 32'(illegal), 32'd0);

        // sw stalled past the limit: 16th stalled cycle traps.
        rst_pulse();
        run_seq(OP_SW, 1'b0, 21, 64'h7);
        chk("to_s3", 32'(obs_state[3]), 32'd5);
        chk("to_s18", 32'(obs_state[18]), 32'd5);
        chk("to_mw17", 32'(obs_mw[17]), 32'd1);
        chk("to_mw18", 32'(obs_mw[18]), 32'd0);
        chk("to_s19", 32'(obs_state[19]), 32'd9);
        chk("to_mw19", 32'(obs_mw[19]), 32'd0);
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_ill", 32'(illegal), 32'd0);

        // Ready arriving exactly at the limit completes normally.
        rst_pulse();
        run_seq(OP_SW, 1'b0, 20, 64'h4_0007);
        chk("edge_mw18", 32'(obs_mw[18]), 32'd1);
        chk("edge_s19", 32'(obs_state[19]), 32'd0);
        chk("edge_berr", 32'(bus_err), 32'd0);

`ifdef RV_INSTRET_EN
        // Wrap of the retire counter.
        rst_pulse();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        run_seq(OP_SW, 1'b0, 4, 64'hF);
        chk("wrap_instret", instret, 32'h0000_0000);
`endif

        // Randomized traffic with stall bursts around the limit and resets.
        rst_pulse();
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            if (burst > 0) begin
                mem_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 29) == 0) begin
                burst = $urandom_range(12, 17);
                mem_ready = 1'b0;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            if (m_cur == 0) begin
                r = $urandom_range(0, 40);
                opcode = (r == 0) ? 7'($urandom) : ops[r % 4];
            end
            zero  = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 249) == 0) || (m_cur == 9 && $urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
